// File: rtl/vector_op_sequencer_if.sv
// vector_op_sequencer_if: command inputs and fetch/store/ALU control outputs of the row sequencer.
interface vector_op_sequencer_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 10
);
    logic                  start;
    logic                  abort;
    logic [ADDR_WIDTH-1:0] base_a;
    logic [ADDR_WIDTH-1:0] base_b;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [LEN_WIDTH-1:0]  len;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  wr_en;
    logic                  alu_start;
    logic                  busy;
    logic                  done;

    modport master (
        output start, abort, base_a, base_b, base_r, len,
        input  addr_a, addr_b, addr_r, wr_en, alu_start, busy, done
    );

    modport slave (
        input  start, abort, base_a, base_b, base_r, len,
        output addr_a, addr_b, addr_r, wr_en, alu_start, busy, done
    );
endinterface

// File: rtl/vector_op_sequencer.sv
// vector_op_sequencer: walks len rows through fetch, BRAM wait, ALU exec and store, one row at a time.
module vector_op_sequencer #(
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 10,
    parameter int BRAM_LAT   = 1,
    parameter int ALU_LAT    = 2
) (
    input logic clk,
    input logic rstn,
    vector_op_sequencer_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_STORE, S_DONE} state_t;

    localparam logic [3:0] BRAM_END = 4'(BRAM_LAT - 1);
    localparam logic [3:0] ALU_END  = 4'(ALU_LAT - 1);

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [LEN_WIDTH-1:0]  r_i;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [ADDR_WIDTH-1:0] r_base_a;
    logic [ADDR_WIDTH-1:0] r_base_b;
    logic [ADDR_WIDTH-1:0] r_base_r;
    logic [ADDR_WIDTH-1:0] r_addr_a;
    logic [ADDR_WIDTH-1:0] r_addr_b;
    logic [ADDR_WIDTH-1:0] r_addr_r;
    logic                  r_wr_en;
    logic                  r_alu_start;
    logic                  r_busy;
    logic                  r_done;
    logic [LEN_WIDTH-1:0]  w_i_nxt;

    assign w_i_nxt       = r_i + 1'b1;
    assign bus.addr_a    = r_addr_a;
    assign bus.addr_b    = r_addr_b;
    assign bus.addr_r    = r_addr_r;
    assign bus.wr_en     = r_wr_en;
    assign bus.alu_start = r_alu_start;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_i         <= '0;
            r_len       <= '0;
            r_base_a    <= '0;
            r_base_b    <= '0;
            r_base_r    <= '0;
            r_addr_a    <= '0;
            r_addr_b    <= '0;
            r_addr_r    <= '0;
            r_wr_en     <= 1'b0;
            r_alu_start <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_wr_en     <= 1'b0;
            r_alu_start <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start && bus.len == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else if (bus.start) begin
                        r_state  <= S_FETCH;
                        r_busy   <= 1'b1;
                        r_i      <= '0;
                        r_len    <= bus.len;
                        r_base_a <= bus.base_a;
                        r_base_b <= bus.base_b;
                        r_base_r <= bus.base_r;
                        r_addr_a <= bus.base_a;
                        r_addr_b <= bus.base_b;
                    end
                end
                S_FETCH: begin
                    r_state <= S_WAIT;
                    r_cnt   <= '0;
                end
                S_WAIT: begin
                    if (r_cnt == BRAM_END) begin
                        r_state     <= S_EXEC;
                        r_cnt       <= '0;
                        r_alu_start <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == ALU_END) begin
                        r_state  <= S_STORE;
                        r_wr_en  <= 1'b1;
                        r_addr_r <= r_base_r + ADDR_WIDTH'(r_i);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STORE: begin
                    if (r_i == r_len - 1'b1) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state  <= S_FETCH;
                        r_i      <= w_i_nxt;
                        r_addr_a <= r_base_a + ADDR_WIDTH'(w_i_nxt);
                        r_addr_b <= r_base_b + ADDR_WIDTH'(w_i_nxt);
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            // Abort wins over anything scheduled above, including the STORE write strobe.
            if (bus.abort && r_busy) begin
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_wr_en     <= 1'b0;
                r_alu_start <= 1'b0;
                r_done      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_vector_op_sequencer.sv
// tb_vector_op_sequencer: directed scenarios plus random commands checked against a row/phase model.
module tb_vector_op_sequencer;
    localparam int AW = 10;
    localparam int LW = 10;
    localparam int BL = 1;
    localparam int AL = 2;
    localparam int P  = 2 + BL + AL;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    vector_op_sequencer_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus();

    vector_op_sequencer #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .BRAM_LAT(BL), .ALU_LAT(AL)) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] off(logic [AW-1:0] b, int r);
        return b + AW'(r);
    endfunction

    // Model: a command is a flat count k of cycles since start; row = k/P, phase = k%P.
    bit            m_act, m_done;
    int            m_k, m_len;
    logic [AW-1:0] m_ba, m_bb, m_br;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_act  <= 1'b0;
            m_done <= 1'b0;
            m_k    <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_act) begin
                if (bus.abort) m_act <= 1'b0;
                else if (m_k + 1 == m_len * P) begin
                    m_act  <= 1'b0;
                    m_done <= 1'b1;
                end else m_k <= m_k + 1;
            end else if (!m_done && bus.start) begin
                if (bus.len == '0) m_done <= 1'b1;
                else begin
                    m_act <= 1'b1;
                    m_k   <= 0;
                    m_len <= int'(bus.len);
                    m_ba  <= bus.base_a;
                    m_bb  <= bus.base_b;
                    m_br  <= bus.base_r;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", bus.busy, m_act);
            chk("done", bus.done, m_done);
            chk("wr_en", bus.wr_en, m_act && (m_k % P == P - 1));
            chk("alu_start", bus.alu_start, m_act && (m_k % P == BL + 1));
            if (m_act && (m_k % P) <= BL) begin
                chk("addr_a", bus.addr_a, off(m_ba, m_k / P));
                chk("addr_b", bus.addr_b, off(m_bb, m_k / P));
            end
            if (m_act && (m_k % P == P - 1)) chk("addr_r", bus.addr_r, off(m_br, m_k / P));
        end
    end

    logic [31:0]   t_busy, t_done, t_wr, t_alu;
    logic [AW-1:0] aa[32], ab[32], ar[32];

    task automatic scen(input logic [AW-1:0] ba, bb, br, input int ln, input bit hold,
                        input int abort_cyc, input int ncyc);
        t_busy = '0; t_done = '0; t_wr = '0; t_alu = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.abort = 1'b0;
        bus.base_a = ba; bus.base_b = bb; bus.base_r = br; bus.len = LW'(ln);
        @(posedge clk);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            t_busy[c] = bus.busy; t_done[c] = bus.done; t_wr[c] = bus.wr_en; t_alu[c] = bus.alu_start;
            aa[c] = bus.addr_a; ab[c] = bus.addr_b; ar[c] = bus.addr_r;
            bus.start = hold && c <= 11;
            bus.abort = (c == abort_cyc);
            if (hold) begin
                bus.base_a = AW'($urandom); bus.base_b = AW'($urandom);
                bus.base_r = AW'($urandom); bus.len = LW'($urandom_range(0, 4));
            end
        end
        bus.start = 1'b0; bus.abort = 1'b0;
    endtask

    task automatic check037(string tag);
        chk({tag, "_busy_trace"}, t_busy, 32'h0000_07FE);
        chk({tag, "_done_trace"}, t_done, 32'h0000_0800);
        chk({tag, "_wr_trace"}, t_wr, 32'h0000_0420);
        chk({tag, "_alu_trace"}, t_alu, 32'h0000_0108);
        chk({tag, "_addr_a1"}, aa[1], 'h010);
        chk({tag, "_addr_a6"}, aa[6], 'h011);
        chk({tag, "_addr_b6"}, ab[6], 'h021);
        chk({tag, "_addr_r5"}, ar[5], 'h030);
        chk({tag, "_addr_r10"}, ar[10], 'h031);
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.base_a = '0; bus.base_b = '0; bus.base_r = '0; bus.len = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_wr", bus.wr_en, 0);
        chk("rst_alu", bus.alu_start, 0);
        chk("rst_addr_a", bus.addr_a, 0);
        chk("rst_addr_r", bus.addr_r, 0);
        rstn = 1'b1;
        chk_on = 1'b1;
        scen('h010, 'h020, 'h030, 2, 1'b0, 0, 14);
        check037("basic");
        scen('h010, 'h020, 'h030, 2, 1'b1, 0, 14);
        check037("hold");
        chk("hold_one_done", $countones(t_done), 1);
        scen('h055, 'h066, 'h077, 0, 1'b0, 0, 4);
        chk("len0_done", t_done, 32'h2);
        chk("len0_busy", t_busy, 0);
        chk("len0_wr", t_wr, 0);
        chk("len0_alu", t_alu, 0);
        scen('h3FF, 'h005, 'h007, 3, 1'b0, 0, 17);
        chk("wrap_a1", aa[1], 'h3FF);
        chk("wrap_a6", aa[6], 'h000);
        chk("wrap_a11", aa[11], 'h001);
        chk("wrap_done", t_done, 32'h0001_0000);
        scen('h010, 'h020, 'h030, 2, 1'b0, 5, 14);
        chk("abort_busy", t_busy, 32'h3E);
        chk("abort_wr_after", t_wr >> 6, 0);
        chk("abort_done", t_done, 0);
        @(negedge clk);
        bus.start = 1'b1; bus.base_a = 'h010; bus.base_b = 'h020; bus.base_r = 'h030; bus.len = 2;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_alu", bus.alu_start, 0);
        chk("mid_rst_wr", bus.wr_en, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_addr_a", bus.addr_a, 0);
        chk("mid_rst_addr_b", bus.addr_b, 0);
        @(negedge clk);
        rstn = 1'b1;
        scen('h010, 'h020, 'h030, 2, 1'b0, 0, 14);
        check037("after_rst");
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 599) == 0) begin
                #2 rstn = 1'b0;
                @(negedge clk);
                rstn = 1'b1;
            end
            bus.start  = ($urandom_range(0, 3) == 0);
            bus.abort  = ($urandom_range(0, 49) == 0);
            bus.base_a = AW'($urandom);
            bus.base_b = AW'($urandom);
            bus.base_r = AW'($urandom);
            bus.len    = LW'($urandom_range(0, 4));
        end
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        repeat (30) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
